// File: rtl/gpmc_pkg.sv
// Shared definitions for the GPMC posted-write scheduler: region codes, local
// register map, CTRL/STATUS bit positions and the buffered write entry layout.
package gpmc_pkg;

  typedef enum logic [1:0] {
    REGION_LOCAL = 2'd0,
    REGION_T1    = 2'd1,
    REGION_T2    = 2'd2,
    REGION_T3    = 2'd3
  } region_e;

  localparam logic [3:0] REG_STATUS  = 4'h0;
  localparam logic [3:0] REG_OVF_CNT = 4'h2;
  localparam logic [3:0] REG_SCRATCH = 4'h4;
  localparam logic [3:0] REG_CTRL    = 4'h6;

  localparam int CTRL_CLR_OVF = 0;
  localparam int CTRL_CLR_TMO = 1;
  localparam int CTRL_FLUSH   = 2;

  localparam int STATUS_OVF   = 8;
  localparam int STATUS_TMO   = 9;
  localparam int STATUS_ISSUE = 10;

  localparam int LEVEL_W = 5;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } drain_state_e;

  typedef struct packed {
    region_e     region;
    logic [14:0] addr;
    logic [15:0] data;
  } wr_entry_t;

  function automatic logic [2:0] region_onehot(input region_e r);
    logic [2:0] oh;
    oh = 3'b000;
    case (r)
      REGION_T1: oh = 3'b001;
      REGION_T2: oh = 3'b010;
      REGION_T3: oh = 3'b100;
      default:   oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/gpmc_wr_sched_if.sv
// Host-side GPMC strobes plus the shared target write/read bus of the scheduler.
interface gpmc_wr_sched_if;
  logic        wr_en;
  logic        rd_en;
  logic        address_valid;
  logic [16:0] address;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic [2:0]  tgt_valid;
  logic [2:0]  tgt_ready;
  logic [14:0] tgt_addr;
  logic [15:0] tgt_wdata;
  logic [2:0]  tgt_rd_en;
  logic [47:0] tgt_rd_data;

  modport slave (
    input  wr_en, rd_en, address_valid, address, wr_data, tgt_ready, tgt_rd_data,
    output rd_data, tgt_valid, tgt_addr, tgt_wdata, tgt_rd_en
  );

  modport master (
    output wr_en, rd_en, address_valid, address, wr_data, tgt_ready, tgt_rd_data,
    input  rd_data, tgt_valid, tgt_addr, tgt_wdata, tgt_rd_en
  );
endinterface

// File: rtl/gpmc_wr_fifo.sv
// Synchronous posted-write buffer with level output and single-cycle flush.
module gpmc_wr_fifo
  import gpmc_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               flush_i,
  input  wr_entry_t          din_i,
  output wr_entry_t          head_o,
  output logic               full_o,
  output logic               empty_o,
  output logic [LEVEL_W-1:0] level_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  wr_entry_t          mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic               do_push, do_pop;

  assign full_o  = (level_q == LEVEL_W'(DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign head_o  = mem_q[rd_ptr_q];

  // A pop frees the slot in the same cycle, so a push into a full buffer still lands.
  assign do_pop  = pop_i && !empty_o && !flush_i;
  assign do_push = push_i && !flush_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      level_d = level_q + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/gpmc_wr_sched.sv
// GPMC write scheduler: posts host writes to three external targets through a
// buffer drained one at a time with ready/timeout, plus a small local register bank.
module gpmc_wr_sched
  import gpmc_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic              gpmc_clk,
  input  logic              rst,
  gpmc_wr_sched_if.slave    bus
);

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  drain_state_e       state_q, state_d;
  logic [7:0]         tmo_cnt_q, tmo_cnt_d;
  logic               ovf_q, tmo_q;
  logic [7:0]         ovf_cnt_q;
  logic [15:0]        scratch_q;

  region_e            region;
  logic [3:0]         loc_off;
  logic               tgt_wr, loc_wr, ctrl_wr;
  logic               clr_ovf, clr_tmo, flush;
  logic               ready_hit, tmo_hit, pop;
  logic               push, ovf_evt;
  logic               issuing;
  wr_entry_t          push_entry, head;
  logic               fifo_full, fifo_empty;
  logic [LEVEL_W-1:0] fifo_level;
  logic [15:0]        status_w;
  logic               unused_addr_bits;

  assign region  = region_e'(bus.address[16:15]);
  assign loc_off = bus.address[3:0];
  assign issuing = (state_q == ST_ISSUE);

  assign tgt_wr  = bus.wr_en && (region != REGION_LOCAL);
  assign loc_wr  = bus.wr_en && (region == REGION_LOCAL);
  assign ctrl_wr = loc_wr && (loc_off == REG_CTRL);
  assign clr_ovf = ctrl_wr && bus.wr_data[CTRL_CLR_OVF];
  assign clr_tmo = ctrl_wr && bus.wr_data[CTRL_CLR_TMO];
  assign flush   = ctrl_wr && bus.wr_data[CTRL_FLUSH];

  assign ready_hit = issuing && |(bus.tgt_ready & region_onehot(head.region));
  assign tmo_hit   = issuing && !ready_hit && (tmo_cnt_q == TMO_LAST) && !flush;
  assign pop       = (ready_hit || tmo_hit) && !flush;

  assign push    = tgt_wr && !flush && (!fifo_full || pop);
  assign ovf_evt = tgt_wr && fifo_full && !pop;

  assign push_entry.region = region;
  assign push_entry.addr   = bus.address[14:0];
  assign push_entry.data   = bus.wr_data;

  gpmc_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (gpmc_clk),
    .rst_i   (rst),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (flush),
    .din_i   (push_entry),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  always_comb begin
    state_d   = state_q;
    tmo_cnt_d = tmo_cnt_q;
    case (state_q)
      ST_IDLE: begin
        tmo_cnt_d = '0;
        if (!fifo_empty && !flush) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (flush || pop) begin
          state_d   = ST_IDLE;
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d   = ST_IDLE;
        tmo_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge gpmc_clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  // Sticky flags: a CTRL clear beats an event arriving in the same cycle.
  always_ff @(posedge gpmc_clk or posedge rst) begin
    if (rst) begin
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
      tmo_q     <= 1'b0;
      scratch_q <= '0;
    end else begin
      if (clr_ovf) begin
        ovf_q     <= 1'b0;
        ovf_cnt_q <= '0;
      end else if (ovf_evt) begin
        ovf_q <= 1'b1;
        if (ovf_cnt_q != 8'hFF) ovf_cnt_q <= ovf_cnt_q + 8'd1;
      end
      if (clr_tmo)      tmo_q <= 1'b0;
      else if (tmo_hit) tmo_q <= 1'b1;
      if (loc_wr && (loc_off == REG_SCRATCH)) scratch_q <= bus.wr_data;
    end
  end

  always_comb begin
    status_w               = '0;
    status_w[LEVEL_W-1:0]  = fifo_level;
    status_w[STATUS_OVF]   = ovf_q;
    status_w[STATUS_TMO]   = tmo_q;
    status_w[STATUS_ISSUE] = issuing;
  end

  always_comb begin
    bus.rd_data = '0;
    if (bus.address_valid) begin
      case (region)
        REGION_LOCAL: begin
          case (loc_off)
            REG_STATUS:  bus.rd_data = status_w;
            REG_OVF_CNT: bus.rd_data = {8'h00, ovf_cnt_q};
            REG_SCRATCH: bus.rd_data = scratch_q;
            default:     bus.rd_data = '0;
          endcase
        end
        REGION_T1: bus.rd_data = bus.tgt_rd_data[15:0];
        REGION_T2: bus.rd_data = bus.tgt_rd_data[31:16];
        REGION_T3: bus.rd_data = bus.tgt_rd_data[47:32];
        default:   bus.rd_data = '0;
      endcase
    end
  end

  // Buffer storage is not reset, so the head is only exposed while issuing.
  assign bus.tgt_valid = issuing ? region_onehot(head.region) : 3'b000;
  assign bus.tgt_addr  = issuing ? head.addr : 15'd0;
  assign bus.tgt_wdata = issuing ? head.data : 16'd0;
  assign bus.tgt_rd_en = (!rst && bus.rd_en) ? region_onehot(region) : 3'b000;

  assign unused_addr_bits = ^{bus.address[0], bus.address[14:4]};

endmodule

// File: doc/gpmc_wr_sched.md
GPMC_WR_SCHED -- requirements
Module: gpmc_wr_sched

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, posted-write buffer entries (power of two, 2..16).
REQ-002 Parameter TIMEOUT, default 255, cycles a target may hold off ready before the write is dropped (1..255).
REQ-003 gpmc_clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 wr_en  in  1  one-cycle host write strobe.
REQ-006 rd_en  in  1  one-cycle host read strobe.
REQ-007 address_valid  in  1  host address latched and stable.
REQ-008 address  in  17  host byte address; bit 0 always 0.
REQ-009 wr_data  in  16  host write data, valid with wr_en.
REQ-010 rd_data  out  16  read data back to host.
REQ-011 tgt_valid  out  3  one-hot write request, one bit per target 1..3.
REQ-012 tgt_ready  in  3  per-target write accept.
REQ-013 tgt_addr  out  15  shared write offset (address[14:0]).
REQ-014 tgt_wdata  out  16  shared write data.
REQ-015 tgt_rd_en  out  3  one-cycle per-target read strobe.
REQ-016 tgt_rd_data  in  48  read data, target n at bits [16n-1:16(n-1)].

Function
REQ-017 Region = address[16:15]: 0 local registers, 1..3 external targets.
REQ-018 wr_en to region 1..3 with FIFO not full pushes {region, address[14:0], wr_data}; never stalls the host.
REQ-019 wr_en to region 1..3 with FIFO full drops the write, sets OVF sticky, increments OVF_COUNT (8 bit, saturates at 255).
REQ-020 Drain FSM states IDLE, ISSUE; IDLE->ISSUE when FIFO non-empty; tgt_valid bit for head region asserts in ISSUE; tgt_addr/tgt_wdata reflect head entry.
REQ-021 ISSUE with matching tgt_ready high at a rising edge: pop, ISSUE->IDLE; minimum one idle cycle between issued writes.
REQ-022 ISSUE held TIMEOUT cycles without ready: pop, set TMO sticky, ISSUE->IDLE.
REQ-023 tgt_valid, tgt_addr, tgt_wdata stay stable while in ISSUE until accepted, timed out or flushed.
REQ-024 Simultaneous push and pop in one cycle both take effect; level unchanged; push into a full FIFO being popped that cycle succeeds.
REQ-025 rd_en to region n (1..3) pulses tgt_rd_en[n-1] in the same cycle (combinational); rd_en to region 0 has no side effects.
REQ-026 rd_data combinational mux from address: region 0 local register, region n tgt_rd_data slice n; 0 when address_valid low.
REQ-027 Local map (region 0, address[3:0]): 0x0 STATUS RO {[4:0] FIFO level, [8] OVF, [9] TMO, [10] FSM in ISSUE}; 0x2 OVF_COUNT RO; 0x4 SCRATCH RW 16 bit; 0x6 CTRL W1 pulse {bit0 clear OVF and OVF_COUNT, bit1 clear TMO, bit2 flush}; other offsets read 0, writes ignored.
REQ-028 Local writes bypass the FIFO and take effect at the next rising edge.
REQ-029 Flush empties FIFO, forces IDLE, deasserts tgt_valid next cycle; a host push in the flush cycle is discarded.
REQ-030 Overflow event and CTRL clear in the same cycle: clear wins.

Reset
REQ-031 rst clears FIFO pointers and level, FSM to IDLE, timeout counter, OVF, TMO, OVF_COUNT, SCRATCH to 0.
REQ-032 Under reset tgt_valid = 0, tgt_rd_en = 0, tgt_addr = 0, tgt_wdata = 0; rd_data follows REQ-026.
REQ-033 rst mid-ISSUE abandons the write with no pop accounting and no TMO.

Structure
REQ-034 Shared package gpmc_pkg holds region codes, local register offsets, CTRL/STATUS bit indices.
REQ-035 FIFO is sub-module gpmc_wr_fifo (sync, depth FIFO_DEPTH, 33-bit entries, level output, flush input).

Verification
REQ-036 Write 0x1234 to 0x08010, target 1 ready after 3 cycles -> tgt_valid=001, tgt_addr=0x0010, tgt_wdata=0x1234 held until accept, STATUS level 0.
REQ-037 Six back-to-back writes to region 2, tgt_ready low -> four queued, OVF=1, OVF_COUNT=2, STATUS level 4.
REQ-038 Region 3 write, tgt_ready never high, TIMEOUT=255 -> tgt_valid drops after 255 cycles, TMO=1, level 0.
REQ-039 Write 0xBEEF to 0x00004, read 0x00004 -> rd_data=0xBEEF; write 0x0007 to 0x00006 -> OVF, TMO, OVF_COUNT 0, FIFO empty.
REQ-040 Read 0x10020 with tgt_rd_data slice 2 = 0xA5A5 -> tgt_rd_en=010 one cycle, rd_data=0xA5A5.
REQ-041 Assert rst while in ISSUE with three entries queued -> all outputs at reset values, level 0, no TMO.
